ca_run_ctrl: RTL and testbench

Run controller for the 32-cell elementary cellular-automaton array. It latches a seed, rule and generation count, then loads the array. It steps the array exactly N generations, or fewer on a fixed point or abort, and freezes it. It returns the final row with a one-cycle done pulse. It sits between the host/register interface and the array, and owns all of the array's control inputs.

---
 rtl/ca_pkg.sv | 19 +
 rtl/ca_boundary_mux.sv | 33 +++
 rtl/ca_run_ctrl.sv | 129 ++++++++++++
 tb/tb_ca_run_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared constants, FSM states and boundary-mode codes for the CA run controller.
// Pure declarations: no logic, no latency, no backpressure.
package ca_pkg;

   localparam int CA_WIDTH = 32;
   localparam int GEN_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] BND_ZERO = 2'd0;
   localparam logic [1:0] BND_ONE  = 2'd1;
   localparam logic [1:0] BND_WRAP = 2'd2;

endpackage

// File: rtl/ca_boundary_mux.sv
// Selects the left/right boundary bits fed into the edge cells of the array.
// Purely combinational, zero latency, no backpressure.
module ca_boundary_mux
   import ca_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       row_msb,
   input  logic       row_lsb,
   output logic       left,
   output logic       right
);

   always_comb begin
      left  = 1'b0;
      right = 1'b0;
      case (mode)
         BND_ONE: begin
            left  = 1'b1;
            right = 1'b1;
         end
         BND_WRAP: begin
            // cell 0's left neighbour is cell 31 and vice versa
            left  = row_msb;
            right = row_lsb;
         end
         default: begin
            left  = 1'b0;
            right = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ca_run_ctrl.sv
// Run controller: loads a seed into the CA array, steps it N generations, returns the row.
// done arrives gens+2 edges after start is sampled; start is ignored while busy (no backpressure).
module ca_run_ctrl
   import ca_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [CA_WIDTH-1:0] seed,
   input  logic [7:0]          rule_in,
   input  logic [GEN_W-1:0]    gens,
   input  logic [1:0]          mode,
   input  logic                halt_en,
   input  logic [CA_WIDTH-1:0] arr_out,
   output logic [7:0]          arr_rule,
   output logic [CA_WIDTH-1:0] arr_state,
   output logic                arr_set,
   output logic                arr_left,
   output logic                arr_right,
   output logic                busy,
   output logic                done,
   output logic [CA_WIDTH-1:0] result,
   output logic [GEN_W-1:0]    gen_count,
   output logic                aborted
);

   state_t              state_q, state_d;
   logic [CA_WIDTH-1:0] seed_q, prev_q, result_q;
   logic [7:0]          rule_q;
   logic [GEN_W-1:0]    gens_q, gen_cnt, gen_count_q;
   logic [1:0]          mode_q;
   logic                halt_q, done_q, aborted_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Outside RUN the array is always loaded: seed in LOAD, itself in DONE, last result in IDLE.
   always_comb begin
      state_d   = state_q;
      arr_set   = 1'b1;
      arr_state = result_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            arr_state = seed_q;
            if (abort || gens_q == '0) state_d = DONE;
            else                       state_d = RUN;
         end
         RUN: begin
            arr_set   = 1'b0;
            arr_state = arr_out;
            if (abort)                                            state_d = DONE;
            else if (gen_cnt == gens_q - GEN_W'(1))               state_d = DONE;
            else if (halt_q && gen_cnt != '0 && arr_out == prev_q) state_d = DONE;
         end
         DONE: begin
            arr_state = arr_out;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_q      <= '0;
         rule_q      <= '0;
         gens_q      <= '0;
         mode_q      <= BND_ZERO;
         halt_q      <= 1'b0;
         gen_cnt     <= '0;
         prev_q      <= '0;
         result_q    <= '0;
         gen_count_q <= '0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  seed_q    <= seed;
                  rule_q    <= rule_in;
                  gens_q    <= gens;
                  mode_q    <= mode;
                  halt_q    <= halt_en;
                  gen_cnt   <= '0;
                  aborted_q <= 1'b0;
               end
            end
            LOAD: begin
               if (abort) aborted_q <= 1'b1;
            end
            RUN: begin
               gen_cnt <= gen_cnt + GEN_W'(1);
               prev_q  <= arr_out;
               if (abort) aborted_q <= 1'b1;
            end
            DONE: begin
               result_q    <= arr_out;
               gen_count_q <= gen_cnt;
               done_q      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   ca_boundary_mux u_bnd (
      .mode    (mode_q),
      .row_msb (arr_out[CA_WIDTH-1]),
      .row_lsb (arr_out[0]),
      .left    (arr_left),
      .right   (arr_right)
   );

   assign arr_rule  = rule_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign result    = result_q;
   assign gen_count = gen_count_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_ca_run_ctrl.sv
// Scoreboard bench for ca_run_ctrl with a behavioural 32-cell array attached.
// The reference model evolves rows generation by generation and applies the stop rules.
module tb_ca_run_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort, halt_en;
   logic [31:0] seed, arr_out, arr_state, result;
   logic [7:0]  rule_in, arr_rule;
   logic [15:0] gens, gen_count;
   logic [1:0]  mode;
   logic        arr_set, arr_left, arr_right, busy, done, aborted;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic done_prev = 1'b0;

   typedef struct {
      logic [31:0] res;
      logic [15:0] gc;
      logic        ab;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   ca_run_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
      .rule_in(rule_in), .gens(gens), .mode(mode), .halt_en(halt_en),
      .arr_out(arr_out), .arr_rule(arr_rule), .arr_state(arr_state),
      .arr_set(arr_set), .arr_left(arr_left), .arr_right(arr_right),
      .busy(busy), .done(done), .result(result), .gen_count(gen_count),
      .aborted(aborted)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] step(input logic [31:0] row, input logic [7:0] rule,
                                        input logic l, input logic r);
      logic [31:0] nx;
      logic a, b;
      nx = '0;
      for (int i = 0; i < 32; i++) begin
         a = (i == 0)  ? l : row[(i + 31) % 32];
         b = (i == 31) ? r : row[(i + 1) % 32];
         nx[i] = rule[{a, row[i], b}];
      end
      return nx;
   endfunction

   // Array under control: boundaries come from the DUT pins.
   logic [31:0] arr_row = '0;
   always @(posedge clk) arr_row <= arr_set ? arr_state : step(arr_row, arr_rule, arr_left, arr_right);
   assign arr_out = arr_row;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model(input logic [31:0] s, input logic [7:0] r, input logic [15:0] g,
                        input logic [1:0] m, input logic h, input int ab_at,
                        output logic [31:0] res, output logic [15:0] gc, output logic ab);
      logic [31:0] rows[$];
      logic l, rr;
      int k;
      ab = 1'b0;
      if (ab_at == 0 || g == 0) begin
         res = s; gc = '0; ab = (ab_at == 0);
         return;
      end
      rows.push_back(s);
      for (k = 1; k <= int'(g); k++) begin
         l  = (m == 2'd1) ? 1'b1 : (m == 2'd2) ? rows[k-1][31] : 1'b0;
         rr = (m == 2'd1) ? 1'b1 : (m == 2'd2) ? rows[k-1][0]  : 1'b0;
         rows.push_back(step(rows[k-1], r, l, rr));
         if (ab_at == k) begin ab = 1'b1; break; end
         if (k == int'(g)) break;
         if (h && k >= 2 && rows[k-1] == rows[k-2]) break;
      end
      res = rows[k];
      gc  = 16'(k);
   endtask

   // Issues one run from an idle negedge; returns at the negedge after done's edge.
   task automatic run(input logic [31:0] s, input logic [7:0] r, input logic [15:0] g,
                      input logic [1:0] m, input logic h, input int ab_at);
      logic [31:0] e_res;
      logic [15:0] e_gc;
      logic        e_ab, seen_low, fin;
      model(s, r, g, m, h, ab_at, e_res, e_gc, e_ab);
      sb.push_back('{e_res, e_gc, e_ab, cyc + int'(e_gc) + 3});
      start = 1'b1; abort = 1'($urandom % 2);
      seed = s; rule_in = r; gens = g; mode = m; halt_en = h;
      @(posedge clk); @(negedge clk);
      seen_low = 1'b0;
      fin = 1'b0;
      for (int c = 0; c < int'(g) + 8; c++) begin
         abort = (c == ab_at);
         start = 1'($urandom % 2);
         seed = $urandom; rule_in = 8'($urandom); gens = 16'($urandom);
         mode = 2'($urandom); halt_en = 1'($urandom);
         if (!arr_set) seen_low = 1'b1;
         @(posedge clk); @(negedge clk);
         if (!busy) begin fin = 1'b1; break; end
      end
      start = 1'b0; abort = 1'b0;
      if (!fin) begin
         n_cmp++; n_bad++;
         $display("FAIL run_timeout: busy still high, required idle within %0d cycles", int'(g) + 8);
         rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
      check("arr_set_low_seen", 32'(seen_low), 32'(e_gc != 0));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         done_prev = 1'b0;
      end else begin
         if (done) begin
            if (done_prev) begin
               n_cmp++; n_bad++;
               $display("FAIL done_width: done high 2 cycles, required 1");
            end
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got done with empty scoreboard, required none");
            end else begin
               e = sb.pop_front();
               check("result", result, e.res);
               check("gen_count", 32'(gen_count), 32'(e.gc));
               check("aborted", 32'(aborted), 32'(e.ab));
               check("done_cycle", 32'(cyc), 32'(e.cyc));
               check("busy_at_done", 32'(busy), 32'd0);
            end
         end
         done_prev = done;
      end
   end

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; rule_in = '0;
      gens = '0; mode = '0; halt_en = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_gen_count", 32'(gen_count), 32'd0);
      check("rst_arr_set", 32'(arr_set), 32'd1);
      check("rst_arr_state", arr_state, 32'd0);
      check("rst_arr_rule", 32'(arr_rule), 32'd0);
      check("rst_arr_row", arr_out, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run(32'h0001_0000, 8'd90,  16'd1,   2'd0, 1'b0, -1);
      run(32'hDEAD_BEEF, 8'd30,  16'd0,   2'd0, 1'b0, -1);
      run(32'h0000_0001, 8'd170, 16'd1,   2'd2, 1'b0, -1);
      run(32'h0000_0001, 8'd170, 16'd1,   2'd0, 1'b0, -1);
      run(32'h1234_5678, 8'd204, 16'd100, 2'd0, 1'b1, -1);
      run(32'h1234_5678, 8'd204, 16'd100, 2'd0, 1'b0, -1);
      run(32'h0001_0000, 8'd30,  16'd50,  2'd0, 1'b0, 5);
      run(32'hA5A5_0F0F, 8'd110, 16'd9,   2'd1, 1'b0, 0);
      run(32'h8000_0001, 8'd150, 16'd7,   2'd1, 1'b0, -1);
      run(32'h8000_0001, 8'd150, 16'd7,   2'd3, 1'b0, -1);

      for (int n = 0; n < 30; n++) begin
         logic [7:0]  r;
         logic [15:0] g;
         int          ab_at;
         case ($urandom % 4)
            0:       r = 8'd204;
            1:       r = 8'd0;
            default: r = 8'($urandom);
         endcase
         g = 16'($urandom_range(0, 40));
         ab_at = ($urandom % 2) ? -1 : int'($urandom_range(0, int'(g) + 1));
         run($urandom, r, g, 2'($urandom), 1'($urandom), ab_at);
      end

      // Reset in the middle of a run: no expectation pushed, no done may appear.
      start = 1'b1; seed = 32'h0F0F_00F0; rule_in = 8'd30; gens = 16'd50;
      mode = 2'd2; halt_en = 1'b0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("midrst_arr_row", arr_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run(32'h0001_0000, 8'd90, 16'd3, 2'd0, 1'b0, -1);

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
